// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for a single memory port, one transaction in flight, with timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default build gives the LSU fixed priority.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        owner_lsu_q, owner_lsu_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        ifu_rv_q, ifu_rv_d;
    logic        lsu_rv_q, lsu_rv_d;

    logic        pick_lsu;
    logic        grant_en;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_lsu_q, last_lsu_d;

    // On a tie the requester that was not granted most recently wins.
    always_comb begin
        pick_lsu = lsu_req && (!ifu_req || !last_lsu_q);
    end
`else
    always_comb begin
        pick_lsu = lsu_req;
    end
`endif

    // Grants are suppressed while reset is asserted; the edge forces IDLE anyway.
    assign grant_en = rst && (state_q == IDLE) && (ifu_req || lsu_req);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_lsu_d = owner_lsu_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        ifu_rv_d    = 1'b0;
        lsu_rv_d    = 1'b0;
        ifu_gnt     = 1'b0;
        lsu_gnt     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_lsu_d  = last_lsu_q;
`endif

        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    lsu_gnt     = pick_lsu;
                    ifu_gnt     = !pick_lsu;
                    owner_lsu_d = pick_lsu;
                    cnt_d       = 8'd0;
                    state_d     = ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_lsu_d  = pick_lsu;
`endif
                    if (pick_lsu) begin
                        we_d    = lsu_we;
                        addr_d  = lsu_addr;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = ifu_addr;
                        wdata_d = 32'd0;
                        wmask_d = 4'd0;
                    end
                end
            end

            ISSUE: begin
                // Timeout takes precedence over a late accept in the same cycle.
                if (cnt_q == TO_LAST) begin
                    rdata_d  = 32'd0;
                    err_d    = 1'b1;
                    ifu_rv_d = !owner_lsu_q;
                    lsu_rv_d = owner_lsu_q;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (mem_ready) begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                // A completion arriving in the timeout cycle still returns real data.
                if (mem_rvalid) begin
                    rdata_d  = mem_rdata;
                    err_d    = 1'b0;
                    ifu_rv_d = !owner_lsu_q;
                    lsu_rv_d = owner_lsu_q;
                    state_d  = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d  = 32'd0;
                    err_d    = 1'b1;
                    ifu_rv_d = !owner_lsu_q;
                    lsu_rv_d = owner_lsu_q;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            owner_lsu_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wmask_q     <= 4'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            ifu_rv_q    <= 1'b0;
            lsu_rv_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_lsu_q <= owner_lsu_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            ifu_rv_q    <= ifu_rv_d;
            lsu_rv_q    <= lsu_rv_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu_q  <= last_lsu_d;
`endif
        end
    end

    assign mem_valid  = (state_q == ISSUE);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wmask  = wmask_q;
    assign busy       = (state_q != IDLE);
    assign ifu_rvalid = ifu_rv_q;
    assign lsu_rvalid = lsu_rv_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles in ISSUE+WAIT before error completion; legal range 2..255.
REQ-002 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-low.
REQ-004 SHALL have port ifu_req  in  1  instruction-fetch read request, held until ifu_gnt.
REQ-005 SHALL have port ifu_addr  in  32  fetch address.
REQ-006 SHALL have port ifu_gnt  out  1  one-cycle accept pulse for IFU.
REQ-007 SHALL have port ifu_rvalid  out  1  one-cycle IFU completion pulse.
REQ-008 SHALL have port lsu_req  in  1  load/store request, held until lsu_gnt.
REQ-009 SHALL have port lsu_we  in  1  1 = store, 0 = load.
REQ-010 SHALL have port lsu_addr  in  32  load/store address.
REQ-011 SHALL have port lsu_wdata  in  32  store data.
REQ-012 SHALL have port lsu_wmask  in  4  store byte mask.
REQ-013 SHALL have port lsu_gnt  out  1  one-cycle accept pulse for LSU.
REQ-014 SHALL have port lsu_rvalid  out  1  one-cycle LSU completion pulse.
REQ-015 SHALL have port rsp_rdata  out  32  shared response data, valid with either rvalid.
REQ-016 SHALL have port rsp_err  out  1  timeout flag, valid with either rvalid.
REQ-017 SHALL have ports mem_valid out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_wmask out 4: request to the single memory port.
REQ-018 SHALL have ports mem_ready in 1, mem_rvalid in 1, mem_rdata in 32: memory accept, completion, read data.
REQ-019 SHALL have port busy  out  1  high when state is not IDLE.

Function
REQ-020 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE with one outstanding transaction.
REQ-021 IDLE: if any req, SHALL pick winner, assert its gnt combinationally that cycle, latch owner/addr/we/wdata/wmask (IFU: we=0, wmask=0, wdata=0), go ISSUE; requests outside IDLE SHALL be ignored, no gnt.
REQ-022 Default priority: lsu_req and ifu_req both high -> LSU wins; loser stays pending.
REQ-023 ISSUE: mem_valid=1 with latched fields stable; mem_ready=1 -> WAIT.
REQ-024 WAIT: mem_rvalid=1 -> register mem_rdata into rsp_rdata, rsp_err=0, pulse owner rvalid next cycle, go IDLE; stores also complete only on mem_rvalid.
REQ-025 Timeout counter SHALL clear on ISSUE entry, increment each ISSUE/WAIT cycle; at count TIMEOUT-1 without completion: rsp_rdata=0, rsp_err=1, owner rvalid next cycle, go IDLE.
REQ-026 mem_rvalid in the timeout cycle SHALL win: normal data, rsp_err=0.
REQ-027 mem_rvalid outside WAIT SHALL be ignored.
REQ-028 Latency: grant cycle G, mem_valid from G+1; rvalid exactly one cycle after mem_rvalid; re-arbitration allowed in the IDLE cycle coinciding with that rvalid pulse.
REQ-029 rsp_rdata/rsp_err SHALL hold value until next completion.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE, counter 0, latched fields 0, all outputs 0; any in-flight transaction is abandoned with no rvalid.
REQ-031 After reset release, stray mem_rvalid from an abandoned transaction SHALL be ignored (REQ-027).

Configuration
REQ-032 With macro ARB_ROUND_ROBIN_EN defined, ties SHALL go to the requester not granted most recently; last-grant register resets to IFU, so first tie goes to LSU.
REQ-033 Without ARB_ROUND_ROBIN_EN, fixed LSU priority (REQ-022) SHALL apply and no last-grant state SHALL exist.

Verification
REQ-034 IFU alone, ifu_addr=0x80000000, mem_ready=1 at once, mem_rvalid 2 cycles later with 0x00000413 -> ifu_gnt at G, mem_addr=0x80000000 at G+1, ifu_rvalid with rsp_rdata=0x00000413, rsp_err=0 one cycle after mem_rvalid.
REQ-035 Both req same cycle, twice in succession -> lsu_gnt first, IFU granted after LSU completion; RR build: second tie grants IFU; fixed build: LSU.
REQ-036 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_ready low 3 cycles -> mem_valid, mem_we=1 and fields stable 4 cycles; lsu_rvalid only after mem_rvalid.
REQ-037 TIMEOUT=8, mem_rvalid never asserted -> owner rvalid at G+9 with rsp_err=1, rsp_rdata=0, busy low after; repeat with mem_rvalid at G+8 -> normal data, rsp_err=0.
REQ-038 rst=0 during WAIT, then mem_rvalid=1 after release -> no rvalid, busy=0, next request served normally.
